// File: rtl/serial_demux_1_to_8.sv
// serial_demux_1_to_8: assembles framed serial bits into an 8-bit word; define DEMUX_PARITY_EN for a trailing even-parity bit
module serial_demux_1_to_8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in,
  input  logic       in_valid,
  input  logic       in_first,
  output logic       in_ready,
  output logic [2:0] sel,
  output logic [7:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       parity_err
);
  typedef enum logic [1:0] {IDLE, FILL, PAR, HOLD} state_t;
  state_t state;
  logic take;
  assign in_ready = state != HOLD;
  assign take = in_valid && in_ready;
`ifdef DEMUX_PARITY_EN
  logic perr;
  assign parity_err = perr;
`else
  assign parity_err = 1'b0;
`endif
  // frame FSM: in_first always restarts a frame; the word is frozen while HOLD waits for the consumer
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sel <= '0;
      frame <= '0;
      frame_valid <= 1'b0;
`ifdef DEMUX_PARITY_EN
      perr <= 1'b0;
`endif
    end else if (take && in_first) begin
      state <= FILL;
      sel <= 3'd1;
      frame <= {7'b0, in};
    end else if (take && state == FILL) begin
      frame[sel] <= in;
      sel <= sel + 3'd1;
      if (sel == 3'd7) begin
`ifdef DEMUX_PARITY_EN
        state <= PAR;
`else
        state <= HOLD;
        frame_valid <= 1'b1;
`endif
      end
    end else if (take && state == PAR) begin
      state <= HOLD;
      frame_valid <= 1'b1;
`ifdef DEMUX_PARITY_EN
      perr <= ^frame ^ in;
`endif
    end else if (state == HOLD && frame_ready) begin
      state <= IDLE;
      frame_valid <= 1'b0;
    end
endmodule

// File: tb/tb_serial_demux_1_to_8.sv
// tb_serial_demux_1_to_8: directed vector table plus multi-cycle sequences for the serial demux
module tb_serial_demux_1_to_8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in = 1'b0;
  logic in_valid = 1'b0;
  logic in_first = 1'b0;
  logic frame_ready = 1'b0;
  logic in_ready;
  logic [2:0] sel;
  logic [7:0] frame;
  logic frame_valid;
  logic parity_err;
  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;

  serial_demux_1_to_8 dut (
    .clk(clk),
    .rst_n(rst_n),
    .in(in),
    .in_valid(in_valid),
    .in_first(in_first),
    .in_ready(in_ready),
    .sel(sel),
    .frame(frame),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v, f, i, fr;
    logic rdy;
    logic [2:0] sel;
    logic [7:0] frm;
    logic fv, pe;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic v, f, i, fr, rdy, input logic [2:0] s, input logic [7:0] frm, input logic fv, pe);
    vec_t t;
    t.v = v; t.f = f; t.i = i; t.fr = fr;
    t.rdy = rdy; t.sel = s; t.frm = frm; t.fv = fv; t.pe = pe;
    tbl.push_back(t);
  endfunction

  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic step(input logic v, f, b, fr);
    @(negedge clk);
    in_valid = v; in_first = f; in = b; frame_ready = fr;
    @(posedge clk);
    #1;
    if (frame_valid) fv_cnt++;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic fr);
    for (int i = 0; i < 8; i++) step(1'b1, i == 0, d[i], fr);
`ifdef DEMUX_PARITY_EN
    step(1'b1, 1'b0, pbit, fr);
`else
    if (pbit) $display("note: parity bit ignored in this build");
`endif
  endtask

  initial begin
    for (int k = 0; k < 4; k++) add(1, 0, 1, 0, 1, 3'd0, 8'h00, 0, 0);
    add(1, 1, 0, 1, 1, 3'd1, 8'h00, 0, 0);
    add(1, 0, 1, 1, 1, 3'd2, 8'h02, 0, 0);
    add(1, 0, 1, 1, 1, 3'd3, 8'h06, 0, 0);
    add(1, 0, 0, 1, 1, 3'd4, 8'h06, 0, 0);
    add(1, 0, 1, 1, 1, 3'd5, 8'h16, 0, 0);
    add(1, 0, 0, 1, 1, 3'd6, 8'h16, 0, 0);
    add(1, 0, 1, 1, 1, 3'd7, 8'h56, 0, 0);
`ifdef DEMUX_PARITY_EN
    add(1, 0, 0, 1, 1, 3'd0, 8'h56, 0, 0);
    add(1, 0, 0, 1, 0, 3'd0, 8'h56, 1, 0);
`else
    add(1, 0, 0, 1, 0, 3'd0, 8'h56, 1, 0);
`endif
    add(0, 0, 0, 1, 1, 3'd0, 8'h56, 0, 0);

    #1;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.sel", sel, 0);
    chk("rst.frame", frame, 0);
    chk("rst.frame_valid", frame_valid, 0);
    chk("rst.parity_err", parity_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      in_valid = tbl[k].v; in_first = tbl[k].f; in = tbl[k].i; frame_ready = tbl[k].fr;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.in_ready", k), in_ready, tbl[k].rdy);
      chk($sformatf("vec%0d.sel", k), sel, tbl[k].sel);
      chk($sformatf("vec%0d.frame", k), frame, tbl[k].frm);
      chk($sformatf("vec%0d.frame_valid", k), frame_valid, tbl[k].fv);
      chk($sformatf("vec%0d.parity_err", k), parity_err, tbl[k].pe);
    end

    fv_cnt = 0;
    step(1, 1, 1, 1);
    step(1, 0, 0, 1);
    step(1, 0, 1, 1);
    chk("resync.partial_no_valid", frame_valid, 0);
    send_frame(8'hA5, 1'b0, 1'b1);
    chk("resync.frame", frame, 8'hA5);
    chk("resync.valid", frame_valid, 1);
    step(0, 0, 0, 1);
    chk("resync.idle", frame_valid, 0);
    chk("resync.pulses", fv_cnt[7:0], 1);

    send_frame(8'hFF, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d.valid", k), frame_valid, 1);
      chk($sformatf("hold%0d.frame", k), frame, 8'hFF);
      chk($sformatf("hold%0d.in_ready", k), in_ready, 0);
      chk($sformatf("hold%0d.sel", k), sel, 0);
      chk($sformatf("hold%0d.parity_err", k), parity_err, 0);
      step(1, k == 4, 0, k == 4);
    end
    chk("hold.release_valid", frame_valid, 0);
    chk("hold.release_ready", in_ready, 1);
    chk("hold.release_sel", sel, 0);
    chk("hold.release_frame", frame, 8'hFF);

`ifdef DEMUX_PARITY_EN
    send_frame(8'h56, 1'b0, 1'b0);
    chk("par0.valid", frame_valid, 1);
    chk("par0.err", parity_err, 0);
    step(0, 0, 0, 1);
    send_frame(8'h56, 1'b1, 1'b0);
    chk("par1.valid", frame_valid, 1);
    chk("par1.err", parity_err, 1);
    step(0, 0, 0, 1);
`endif

    fv_cnt = 0;
    step(1, 1, 1, 1);
    step(1, 0, 1, 1);
    step(1, 0, 1, 1);
    step(1, 0, 1, 1);
    chk("mid.sel", sel, 4);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mid_rst.in_ready", in_ready, 1);
    chk("mid_rst.sel", sel, 0);
    chk("mid_rst.frame", frame, 0);
    chk("mid_rst.frame_valid", frame_valid, 0);
    chk("mid_rst.parity_err", parity_err, 0);
    @(posedge clk);
    #1;
    if (frame_valid) fv_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst.no_pulse", fv_cnt[7:0], 0);
    send_frame(8'h3C, 1'b0, 1'b1);
    chk("after_rst.frame", frame, 8'h3C);
    chk("after_rst.valid", frame_valid, 1);
    chk("after_rst.pulses", fv_cnt[7:0], 1);
    step(0, 0, 0, 1);
    chk("after_rst.idle", frame_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_demux_1_to_8.md
SERIAL_DEMUX_1_TO_8 -- requirements
Module: serial_demux_1_to_8

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in  input  1  serial data bit.
REQ-005 in_valid  input  1  in is offered this cycle.
REQ-006 in_first  input  1  qualifies in as bit 0 of a new frame (meaningful only with in_valid).
REQ-007 in_ready  output  1  block accepts in this cycle; a bit is accepted when in_valid && in_ready.
REQ-008 sel  output  3  index of the frame bit the next accepted data bit is written to.
REQ-009 frame  output  8  assembled parallel word; frame[k] is data bit k of the frame.
REQ-010 frame_valid  output  1  frame is complete and stable.
REQ-011 frame_ready  input  1  consumer takes frame when frame_valid && frame_ready.
REQ-012 parity_err  output  1  parity check result, valid while frame_valid is high.

Function
REQ-013 The block SHALL implement states IDLE, FILL, PAR and HOLD; after reset, state is IDLE.
REQ-014 in_ready SHALL be combinational: 1 in IDLE, FILL and PAR; 0 in HOLD.
REQ-015 In IDLE, an accepted bit with in_first=1 SHALL clear frame, write frame[0]=in, set sel=1 and move to FILL; an accepted bit with in_first=0 SHALL be dropped.
REQ-016 In FILL, an accepted bit with in_first=0 SHALL write frame[sel]=in and increment sel by 1.
REQ-017 When sel wraps from 7 to 0 in FILL, the next state SHALL be PAR if DEMUX_PARITY_EN is defined, else HOLD.
REQ-018 An accepted bit with in_first=1 in FILL or PAR SHALL resynchronise: the partial frame is discarded and the REQ-015 start action is taken.
REQ-019 In PAR, an accepted bit with in_first=0 is the parity bit and SHALL move the state to HOLD.
REQ-020 frame_valid SHALL be 1 exactly while in HOLD, rising the cycle after the last bit is accepted; frame and parity_err SHALL be stable in HOLD.
REQ-021 In HOLD, frame_ready=1 SHALL move the state to IDLE on that edge; frame keeps its value until the next frame starts.
REQ-022 in_valid in HOLD SHALL be ignored, including in the cycle where frame_ready=1.
REQ-023 sel SHALL read 0 in IDLE, PAR and HOLD.

Reset
REQ-024 While rst_n=0: state=IDLE, sel=0, frame=8'h00, frame_valid=0, parity_err=0, and hence in_ready=1.
REQ-025 Reset mid-frame SHALL discard all captured bits, with no frame_valid pulse.

Configuration
REQ-026 Macro DEMUX_PARITY_EN defined: PAR state exists, and parity_err = XOR of the 8 data bits and the parity bit (even parity; 1 = error), registered on entry to HOLD.
REQ-027 Macro DEMUX_PARITY_EN undefined: PAR is never entered, a frame is 8 bits, and parity_err is tied to 0.

Verification
REQ-028 Parity off; bits 0,1,1,0,1,0,1,0 (first on bit 0) with in_valid=1 back-to-back and frame_ready=1 -> frame=8'h56, frame_valid high for 1 cycle, 1 cycle after the 8th bit.
REQ-029 Parity off; after 3 bits, in_first=1 with a new 8-bit frame 8'hA5 -> frame=8'hA5, and only one frame_valid pulse.
REQ-030 Parity off; frame 8'hFF with frame_ready=0 for 5 cycles, and in_valid held 1 -> frame_valid and frame=8'hFF held 5 cycles, in_ready=0, then IDLE; the held input bits are not captured.
REQ-031 Parity on; 8'h56 followed by parity bit 0 -> parity_err=0; the same with parity bit 1 -> parity_err=1.
REQ-032 rst_n pulsed low after 4 bits of a frame -> outputs match REQ-024, and the next in_first frame 8'h3C is captured correctly.
REQ-033 in_valid=1, in_first=0 in IDLE for 4 cycles -> sel stays 0, frame is unchanged, and no frame_valid.
